// File: rtl/muldiv_sequencer.sv
// Iterative MIPS-style multiply/divide unit: Booth or shift-add multiply, or restoring divide.
// Each operation takes one iteration per operand bit, then a fixup cycle and a done cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             pc_we
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DONE} state_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;

    state_t             state_reg, state_next;
    logic [1:0]         op_reg, op_next;
    logic [WIDTH-1:0]   rs_reg, rs_next;
    logic [WIDTH-1:0]   rt_reg, rt_next;
    logic [WIDTH:0]     acc_reg, acc_next;
    logic [WIDTH-1:0]   q_reg, q_next;
    logic               lo_m1_reg, lo_m1_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               dbz_reg, dbz_next;

    logic [WIDTH:0]     m_ext;
    logic [WIDTH-1:0]   start_mag, rt_mag, rem;
    logic               rs_neg, rt_neg;
    logic [WIDTH:0]     step_acc, sum_w, rem_shift;
    logic [WIDTH-1:0]   step_q;
    logic               step_lo_m1;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_dbz;

    // Divides iterate on magnitudes; only signed DIV has negative operands
    assign start_mag = (op == OP_DIV && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rs_neg    = (op_reg == OP_DIV) && rs_reg[WIDTH-1];
    assign rt_neg    = (op_reg == OP_DIV) && rt_reg[WIDTH-1];
    assign rt_mag    = rt_neg ? -rt_reg : rt_reg;
    assign m_ext     = (op_reg == OP_MULT) ? {rs_reg[WIDTH-1], rs_reg} : {1'b0, rs_reg};
    assign rem       = acc_reg[WIDTH-1:0];

    // One iteration of the selected algorithm
    always_comb begin
        step_acc   = acc_reg;
        step_q     = q_reg;
        step_lo_m1 = lo_m1_reg;
        sum_w      = '0;
        rem_shift  = '0;
        diff       = '0;
        case (op_reg)
            OP_MULT: begin
                case ({q_reg[0], lo_m1_reg})
                    2'b01:   sum_w = acc_reg + m_ext;
                    2'b10:   sum_w = acc_reg - m_ext;
                    default: sum_w = acc_reg;
                endcase
                step_acc   = {sum_w[WIDTH], sum_w[WIDTH:1]};
                step_q     = {sum_w[0], q_reg[WIDTH-1:1]};
                step_lo_m1 = q_reg[0];
            end
            OP_MULTU: begin
                sum_w    = q_reg[0] ? acc_reg + m_ext : acc_reg;
                step_acc = {1'b0, sum_w[WIDTH:1]};
                step_q   = {sum_w[0], q_reg[WIDTH-1:1]};
            end
            default: begin
                rem_shift = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
                diff      = {1'b0, rem_shift} - {2'b00, rt_mag};
                if (!diff[WIDTH+1]) begin
                    step_acc = diff[WIDTH:0];
                    step_q   = {q_reg[WIDTH-2:0], 1'b1};
                end else begin
                    step_acc = rem_shift;
                    step_q   = {q_reg[WIDTH-2:0], 1'b0};
                end
            end
        endcase
    end

    // Final HI/LO values; the multiply product is {acc, q} directly
    always_comb begin
        res_hi  = acc_reg[WIDTH-1:0];
        res_lo  = q_reg;
        res_dbz = 1'b0;
        if (op_reg[1]) begin
            if (rt_reg == '0) begin
                res_hi  = rs_reg;
                res_lo  = '1;
                res_dbz = 1'b1;
            end else if (op_reg == OP_DIV) begin
                res_lo = (rs_neg ^ rt_neg) ? -q_reg : q_reg;
                res_hi = rs_neg ? -rem : rem;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        rs_next    = rs_reg;
        rt_next    = rt_reg;
        acc_next   = acc_reg;
        q_next     = q_reg;
        lo_m1_next = lo_m1_reg;
        cnt_next   = cnt_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        dbz_next   = dbz_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                    op_next    = op;
                    rs_next    = rs_val;
                    rt_next    = rt_val;
                    acc_next   = '0;
                    q_next     = op[1] ? start_mag : rt_val;
                    lo_m1_next = 1'b0;
                    cnt_next   = CNT_W'(WIDTH - 1);
                    dbz_next   = 1'b0;
                end else begin
                    if (hi_we) hi_next = wr_data;
                    if (lo_we) lo_next = wr_data;
                end
            end
            S_RUN: begin
                acc_next   = step_acc;
                q_next     = step_q;
                lo_m1_next = step_lo_m1;
                if (cnt_reg == '0) state_next = S_FIXUP;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            S_FIXUP: begin
                state_next = S_DONE;
                hi_next    = res_hi;
                lo_next    = res_lo;
                dbz_next   = res_dbz;
            end
            default: state_next = S_IDLE;
        endcase
        // Abort wins over everything except in IDLE, where it is meaningless
        if (flush && state_reg != S_IDLE) begin
            state_next = S_IDLE;
            hi_next    = hi_reg;
            lo_next    = lo_reg;
            dbz_next   = dbz_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            op_reg    <= '0;
            rs_reg    <= '0;
            rt_reg    <= '0;
            acc_reg   <= '0;
            q_reg     <= '0;
            lo_m1_reg <= 1'b0;
            cnt_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            rs_reg    <= rs_next;
            rt_reg    <= rt_next;
            acc_reg   <= acc_next;
            q_reg     <= q_next;
            lo_m1_reg <= lo_m1_next;
            cnt_reg   <= cnt_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            dbz_reg   <= dbz_next;
        end
    end

    assign hi          = hi_reg;
    assign lo          = lo_reg;
    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_DONE) && !flush;
    assign div_by_zero = done && dbz_reg;
    assign pc_we       = (state_reg == S_IDLE) && !start;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (WIDTH=32): fixed vectors with hand-computed results.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        flush, hi_we, lo_we;
    logic [31:0] wr_data;
    logic [31:0] hi, lo;
    logic        busy, done, div_by_zero, pc_we;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
        .hi(hi), .lo(lo), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .pc_we(pc_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start at the current negedge (cycle 0); done is expected in cycle 34
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic ed, input logic fl);
        int early;
        int pcw;
        early = 0;
        pcw   = 0;
        start = 1'b1; op = o; rs_val = a; rt_val = b; flush = fl;
        #1 check({tag, " pc_we@0"}, pc_we, 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0; rs_val = '0; rt_val = '0;
        check({tag, " busy@1"}, busy, 1);
        for (int c = 1; c <= 33; c++) begin
            if (done) early++;
            if (pc_we) pcw++;
            @(negedge clk);
        end
        check({tag, " early_done"}, early, 0);
        check({tag, " pc_we_stall"}, pcw, 0);
        check({tag, " done@34"}, done, 1);
        check({tag, " dbz"}, div_by_zero, ed);
        check({tag, " hi"}, hi, eh);
        check({tag, " lo"}, lo, el);
        $display("%s: hi=%08h lo=%08h dbz=%0b", tag, hi, lo, div_by_zero);
        @(negedge clk);
        check({tag, " done@35"}, done, 0);
        check({tag, " idle@35"}, busy, 0);
    endtask

    initial begin
        int dcount;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
        #12;
        check("rst hi", hi, 0);
        check("rst lo", lo, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst dbz", div_by_zero, 0);
        check("rst pc_we", pc_we, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // mthi and mtlo in the same cycle
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h11;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi", hi, 32'h11);
        check("mtlo", lo, 32'h11);
        $display("mthi/mtlo: hi=%08h lo=%08h", hi, lo);

        run_op("MULT -3*7",   2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
        run_op("MULTU max^2", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        run_op("DIV -7/2",    2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
        run_op("DIVU 100/7",  2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 1'b0);
        run_op("DIVU 100/0",  2'b11, 32'h64,        32'd0,        32'h64,        32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("DIV min/-1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0, 1'b0);

        // mtlo 5, then MULT with a stray start, a blocked mthi and a flush
        lo_we = 1'b1; wr_data = 32'd5;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo 5", lo, 5);
        start = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start   = (c == 3);
            hi_we   = (c == 5);
            wr_data = (c == 5) ? 32'hBAD : 32'h0;
            flush   = (c == 10);
        end
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; flush = 1'b0;
        check("flush idle@11", busy, 0);
        check("flush lo kept", lo, 5);
        check("flush hi kept", hi, 0);
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        check("flush no done", dcount, 0);
        $display("flush: busy=%0b hi=%08h lo=%08h done_pulses=%0d", busy, hi, lo, dcount);

        // Asynchronous reset in the middle of RUN
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h66;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = 2'b00; rs_val = 32'd9; rt_val = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst hi", hi, 0);
        check("arst lo", lo, 0);
        check("arst busy", busy, 0);
        check("arst done", done, 0);
        check("arst pc_we", pc_we, 1);
        $display("async reset: hi=%08h lo=%08h busy=%0b", hi, lo, busy);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // start and mthi together: start wins
        start = 1'b1; op = 2'b00; rs_val = 32'd6; rt_val = 32'd7; hi_we = 1'b1; wr_data = 32'h1234;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("start wins hi", hi, 0);
        check("start wins busy", busy, 1);
        repeat (33) @(negedge clk);
        check("MULT 6*7 done", done, 1);
        check("MULT 6*7 hi", hi, 0);
        check("MULT 6*7 lo", lo, 42);
        $display("MULT 6*7: hi=%08h lo=%08h", hi, lo);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
